// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state type and access-legality helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WRITE,
    S_RESP
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: is_misaligned = addr_lo[0];
      F3_W:        is_misaligned = (addr_lo != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  // Stores only have B/H/W encodings; loads reject 011, 110 and 111.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we)
      is_illegal = (funct3 > F3_W);
    else
      is_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends load data and merges sub-word store data (little-endian).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    o_load_data = i_word;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_word;
    endcase

    o_store_word = i_word;
    case (i_funct3[1:0])
      2'b00: begin
        case (i_addr_lo)
          2'd0: o_store_word[7:0]   = i_wdata[7:0];
          2'd1: o_store_word[15:8]  = i_wdata[7:0];
          2'd2: o_store_word[23:16] = i_wdata[7:0];
          2'd3: o_store_word[31:24] = i_wdata[7:0];
          default: o_store_word = i_word;
        endcase
      end
      2'b01: begin
        if (i_addr_lo[1])
          o_store_word[31:16] = i_wdata[15:0];
        else
          o_store_word[15:0] = i_wdata[15:0];
      end
      default: o_store_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I byte-addressed loads/stores onto a word RAM; load 2 cycles, SW 2, SB/SH 3, error 1 to done.
// One access in flight: ready only in IDLE, requests while busy are ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int data_width = 32,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic [addr_width-1:0] ram_read_address,
  output logic [addr_width-1:0] ram_write_address,
  output logic                  ram_write,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  lsu_state_t              r_state, w_next;
  logic                    r_we;
  logic [2:0]              r_funct3;
  logic [addr_width+1:0]   r_addr;
  logic [31:0]             r_din;
  logic [31:0]             r_rdata;
  logic                    r_err;
  logic                    w_bad;
  logic [31:0]             w_load_data;
  logic [31:0]             w_store_word;
  logic                    w_unused_addr;

  assign w_unused_addr = ^req_addr[31:addr_width+2];
  assign w_bad = is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_bad)
            w_next = S_RESP;
          else if (req_we && (req_funct3 == F3_W))
            w_next = S_WRITE;
          else
            w_next = S_RD_WAIT;
        end
      end
      S_RD_WAIT: w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE:   w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // r_din holds the raw store data until RD_WAIT turns it into the merged word for sub-word stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_din    <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && req) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[addr_width+1:0];
        r_din    <= req_wdata;
        r_rdata  <= 32'd0;
        r_err    <= w_bad;
      end else if (r_state == S_RD_WAIT) begin
        if (r_we)
          r_din <= w_store_word;
        else
          r_rdata <= w_load_data;
      end
    end
  end

  lsu_lane_align u_lane_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_word       (ram_dout),
    .i_wdata      (r_din),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  assign ready             = (r_state == S_IDLE);
  assign done              = (r_state == S_RESP);
  assign err               = (r_state == S_RESP) && r_err;
  assign rdata             = r_rdata;
  assign ram_read_address  = (r_state == S_IDLE) ? req_addr[addr_width+1:2] : r_addr[addr_width+1:2];
  assign ram_write_address = r_addr[addr_width+1:2];
  assign ram_write         = (r_state == S_WRITE);
  assign ram_din           = r_din;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word registered-read RAM model and hand-computed vectors.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [3:0]  ram_read_address;
  logic [3:0]  ram_write_address;
  logic        ram_write;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [16];
  logic        bk_we;
  logic [3:0]  bk_wa;
  logic [31:0] bk_wd;
  int          wcnt;

  int          n_vec;
  int          n_miss;
  logic [31:0] g_rdata;
  logic        g_err;
  int          g_lat;
  int          g_wr;

  load_store_unit #(.data_width(32), .addr_width(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .req_we            (req_we),
    .req_funct3        (req_funct3),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .ready             (ready),
    .done              (done),
    .err               (err),
    .rdata             (rdata),
    .ram_read_address  (ram_read_address),
    .ram_write_address (ram_write_address),
    .ram_write         (ram_write),
    .ram_din           (ram_din),
    .ram_dout          (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    wcnt = 0;
  end

  always @(posedge clk) begin
    if (ram_write) begin
      mem[ram_write_address] <= ram_din;
      wcnt <= wcnt + 1;
    end else if (bk_we) begin
      mem[bk_wa] <= bk_wd;
    end
    ram_dout <= mem[ram_read_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    int w0;
    @(negedge clk);
    chk("ready_before", {31'd0, ready}, 32'd1);
    req = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    w0 = wcnt;
    @(posedge clk);
    #1;
    req = 1'b0;
    g_lat = 1;
    while (!done && g_lat < 8) begin
      @(posedge clk);
      #1;
      g_lat++;
    end
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    g_rdata = rdata;
    g_err   = err;
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("ready_after", {31'd0, ready}, 32'd1);
    g_wr = wcnt - w0;
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp);
    access(1'b0, f3, addr, 32'd0);
    chk({tag, "_lat"}, g_lat, 32'd2);
    chk({tag, "_err"}, {31'd0, g_err}, 32'd0);
    chk({tag, "_rdata"}, g_rdata, exp);
  endtask

  task automatic bad(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr);
    access(we, f3, addr, 32'hFFFF_FFFF);
    chk({tag, "_lat"}, g_lat, 32'd1);
    chk({tag, "_err"}, {31'd0, g_err}, 32'd1);
    chk({tag, "_rdata"}, g_rdata, 32'd0);
    chk({tag, "_writes"}, g_wr, 32'd0);
  endtask

  initial begin
    int w0;
    int ndone;
    n_vec = 0; n_miss = 0;
    reset = 1'b1; req = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    bk_we = 1'b1; bk_wa = 4'd3; bk_wd = 32'h8899_AABB;
    @(posedge clk);
    #1;
    bk_we = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ram_write", {31'd0, ram_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    load("lb_0d", 3'b000, 32'h0D, 32'hFFFF_FFAA);
    load("lhu_0e", 3'b101, 32'h0E, 32'h0000_8899);
    load("lh_0e", 3'b001, 32'h0E, 32'hFFFF_8899);

    access(1'b1, 3'b000, 32'h0D, 32'h1234_5677);
    chk("sb_lat", g_lat, 32'd3);
    chk("sb_err", {31'd0, g_err}, 32'd0);
    chk("sb_rdata", g_rdata, 32'd0);
    chk("sb_writes", g_wr, 32'd1);
    chk("sb_mem3", mem[3], 32'h8899_77BB);
    load("lb_after_sb", 3'b000, 32'h0D, 32'h0000_0077);
    load("lbu_0f", 3'b100, 32'h0F, 32'h0000_0088);

    access(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF);
    chk("sw_lat", g_lat, 32'd2);
    chk("sw_writes", g_wr, 32'd1);
    chk("sw_mem2", mem[2], 32'hDEAD_BEEF);
    load("lw_08", 3'b010, 32'h08, 32'hDEAD_BEEF);
    load("lw_wrap_48", 3'b010, 32'h48, 32'hDEAD_BEEF);
    bad("lw_09", 1'b0, 3'b010, 32'h09);

    bad("sh_0f", 1'b1, 3'b001, 32'h0F);
    chk("sh_0f_mem3", mem[3], 32'h8899_77BB);
    bad("ld_f3_011", 1'b0, 3'b011, 32'h0C);
    bad("st_f3_100", 1'b1, 3'b100, 32'h0C);
    chk("bad_st_mem3", mem[3], 32'h8899_77BB);

    access(1'b1, 3'b001, 32'h0E, 32'hABCD_1357);
    chk("sh_lat", g_lat, 32'd3);
    chk("sh_writes", g_wr, 32'd1);
    chk("sh_mem3", mem[3], 32'h1357_77BB);

    // Abandon an SB while it waits on the old word.
    @(negedge clk);
    w0 = wcnt;
    req = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0C; req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1;
    req = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_ram_write", {31'd0, ram_write}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("rst_mid_no_done", ndone, 32'd0);
    chk("rst_mid_writes", wcnt - w0, 32'd0);
    chk("rst_mid_mem3", mem[3], 32'h1357_77BB);
    chk("rst_mid_ready_later", {31'd0, ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
